// File: rtl/end_screen_ctrl_if.sv
// End-of-game overlay sequencer bus: frame/event inputs and overlay/control outputs.
// master = game side driving events, slave = end_screen_ctrl.
interface end_screen_ctrl_if;
    logic       vsync_in;
    logic       collision;
    logic       win;
    logic       key_restart;
    logic       game_over;
    logic       victory;
    logic       game_freeze;
    logic       restart;
    logic [1:0] state_out;

    modport master (
        output vsync_in, collision, win, key_restart,
        input  game_over, victory, game_freeze, restart, state_out
    );

    modport slave (
        input  vsync_in, collision, win, key_restart,
        output game_over, victory, game_freeze, restart, state_out
    );
endinterface

// File: rtl/end_screen_ctrl.sv
// End-of-game overlay sequencer: PLAY -> FREEZE -> SHOW -> RESTART, timed in vsync frames.
// Optional BLINK_EN: overlay flags blink with period BLINK_FRAMES during SHOW.
module end_screen_ctrl #(
    parameter int FREEZE_FRAMES   = 30,
    parameter int MIN_SHOW_FRAMES = 60,
    parameter int BLINK_FRAMES    = 32,
    parameter int CNT_W           = 8
) (
    input logic             pclk,
    input logic             rst_n,
    end_screen_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        FREEZE  = 2'd1,
        SHOW    = 2'd2,
        RESTART = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FRZ_LAST = CNT_W'(FREEZE_FRAMES - 1);
    localparam logic [CNT_W-1:0] SHOW_MIN = CNT_W'(MIN_SHOW_FRAMES);

    state_t           state;
    logic             res_win;
    logic [CNT_W-1:0] frame_cnt;
    logic             vsync_q;
    logic             key_q;
    logic             go_q;
    logic             vic_q;
    logic             frz_q;
    logic             rst_q;
    logic             tick;
    logic             key_edge;
    logic             show_on;

    assign tick     = bus.vsync_in & ~vsync_q;
    assign key_edge = bus.key_restart & ~key_q;

`ifdef BLINK_EN
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLK_HALF = CNT_W'(BLINK_FRAMES / 2);

    logic [CNT_W-1:0] blink_cnt;
    logic [CNT_W-1:0] blink_nxt;

    // Next blink phase; flags follow the phase being entered on a tick
    always_comb begin
        blink_nxt = (blink_cnt == BLK_LAST) ? '0 : blink_cnt + 1'b1;
        show_on   = (blink_nxt < BLK_HALF);
    end
`else
    assign show_on = 1'b1;
`endif

    // Sequencer FSM; outputs registered from the state being entered
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PLAY;
            res_win   <= 1'b0;
            frame_cnt <= '0;
            vsync_q   <= 1'b0;
            key_q     <= 1'b0;
            go_q      <= 1'b0;
            vic_q     <= 1'b0;
            frz_q     <= 1'b0;
            rst_q     <= 1'b0;
`ifdef BLINK_EN
            blink_cnt <= '0;
`endif
        end else begin
            vsync_q <= bus.vsync_in;
            key_q   <= bus.key_restart;
            rst_q   <= 1'b0;
            unique case (state)
                PLAY: begin
                    if (bus.collision || bus.win) begin
                        state     <= FREEZE;
                        res_win   <= ~bus.collision;
                        frame_cnt <= '0;
                        frz_q     <= 1'b1;
                    end
                end
                FREEZE: begin
                    if (tick) begin
                        if (frame_cnt == FRZ_LAST) begin
                            state     <= SHOW;
                            frame_cnt <= '0;
                            go_q      <= ~res_win;
                            vic_q     <= res_win;
`ifdef BLINK_EN
                            blink_cnt <= '0;
`endif
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (key_edge && frame_cnt == SHOW_MIN) begin
                        state <= RESTART;
                        rst_q <= 1'b1;
                        go_q  <= 1'b0;
                        vic_q <= 1'b0;
                    end else if (tick) begin
                        if (frame_cnt < SHOW_MIN) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                        go_q  <= ~res_win & show_on;
                        vic_q <= res_win & show_on;
`ifdef BLINK_EN
                        blink_cnt <= blink_nxt;
`endif
                    end
                end
                RESTART: begin
                    state <= PLAY;
                    frz_q <= 1'b0;
                    go_q  <= 1'b0;
                    vic_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.game_over   = go_q;
    assign bus.victory     = vic_q;
    assign bus.game_freeze = frz_q;
    assign bus.restart     = rst_q;
    assign bus.state_out   = state;

endmodule
